collision_tracker: RTL
======================

// Module: collision_tracker
// PURPOSE
//  Parametrised collision/lives tracker for the LED-matrix Flappy Bird game.
//  - Compares the bird's one-hot row vector with the pipe column occupancy vector.
//  - Adds a multi-life model, a post-hit invincibility window and a sticky game-over.
//  - Sits between the bird/pipe column generators and the display/score logic.
//  - Drives loss_detect to the top-level game FSM.
// PARAMETERS
//  ROWS        8  height of the matrix = width of bird/pipe vectors
//  LIVES       3  lives at start (>=1)
//  GRACE_TICKS 4  game ticks of invincibility after a non-fatal pipe hit (0 = none)
// PORTS
//  clock        in   1                 system clock; single clock domain
//  reset        in   1                 synchronous, active-low; restores all reset values
//  tick         in   1                 game-step strobe, 1 cycle wide; all evaluation gated by it
//  restart      in   1                 synchronous new-game request; same effect as reset
//  bird         in   ROWS              bird row, expected one-hot
//  pipe         in   ROWS              pipe pixels in the bird's column
//  ground_hit   in   1                 bird touched the ground
//  hit_pulse    out  1                 1-cycle pulse when a life is lost
//  lives_left   out  $clog2(LIVES+1)   remaining lives
//  grace_active out  1                 invincibility window running
//  loss_detect  out  1                 game over; sticky
// BEHAVIOUR
//  - Reset values: state PLAY, lives_left=LIVES, hit_pulse=0, grace_active=0,
//    loss_detect=0, grace count=0.
//  - All outputs are registered.
//  - Priority: reset (low) > restart > tick logic. restart=1 reloads the reset values
//    on the next edge from any state.
//  - pipe_coll = |(bird & pipe). This is an OR reduction, so any overlap is a hit
//    regardless of how many rows overlap.
//  - Sampled only on a cycle with tick=1; with tick=0 the state holds and
//    hit_pulse returns to 0.
//  - PLAY:
//    - tick & ground_hit -> DEAD, lives_left=0, hit_pulse=1. Ground is always fatal.
//    - tick & pipe_coll & lives_left==1 -> DEAD, lives_left=0, hit_pulse=1.
//    - tick & pipe_coll & lives_left>1 -> lives_left-1, hit_pulse=1, then:
//      - GRACE_TICKS>0: go to GRACE, load count=GRACE_TICKS.
//      - GRACE_TICKS==0: stay in PLAY.
//  - GRACE:
//    - grace_active=1; pipe_coll ignored.
//    - tick & ground_hit -> DEAD as in PLAY (grace does not protect from ground).
//    - Otherwise each tick decrements the count; a tick with count==1 -> PLAY,
//      grace_active=0 on that edge.
//  - DEAD: loss_detect=1, grace_active=0; exit only via reset or restart.
//  - hit_pulse is high for exactly the one cycle after the triggering tick edge.
//  - lives_left never underflows.
//  - Simultaneous ground_hit and pipe_coll: treated as ground, so hit_pulse fires once.
//  - bird all-zero: no pipe collision. Multi-hot bird: still evaluated as an OR reduction.
// CONFIGURATION
//  - SCORE_EN defined: adds output `score` (8 bits, reset 0, saturates at 255).
//    - In PLAY or GRACE, a tick where the previous tick's pipe was nonzero and the
//      current pipe is zero counts as a passed pipe. It increments score, unless this
//      tick also causes DEAD.
//    - restart clears score.
//  - SCORE_EN undefined: no score port and no score/prev-pipe registers.
// STRUCTURE
//  - Package collision_pkg:
//    - typedef enum logic [1:0] {PLAY, GRACE, DEAD} coll_state_t
//    - lives width localparam helper
//    - SCORE_W=8
//  - Sub-module grace_timer:
//    - Loadable down-counter with inputs load, value, tick.
//    - Outputs active, expire (count==1 & tick).
//    - Parametrised by GRACE_TICKS.
// TESTING
//  1. Reset low 2 cycles -> lives_left=3, loss_detect=0, grace_active=0, hit_pulse=0.
//  2. tick with bird=8'h04, pipe=8'h04 -> hit_pulse 1 cycle, lives_left=2,
//     grace_active=1. Same overlap on next 3 ticks -> no change. 4th tick -> grace_active=0.
//  3. Three separated pipe hits -> lives 3->2->1->0. Third hit sets loss_detect=1,
//     held for 10+ ticks with no inputs.
//  4. ground_hit=1 on tick during GRACE with lives_left=2 -> loss_detect=1, lives_left=0,
//     single hit_pulse.
//  5. Overlap present with tick=0 for 5 cycles -> no change.
//     restart=1 while DEAD -> reset values next cycle.
//  6. SCORE_EN: pipe 8'hE7 on a tick, then 8'h00 on the next tick with no collision ->
//     score=1. 300 passes -> score=255.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and constants for the Flappy Bird collision/lives tracker.
package collision_pkg;

    typedef enum logic [1:0] {PLAY, GRACE, DEAD} coll_state_t;

    localparam int unsigned SCORE_W = 8;

    // Width needed to hold 0..lives inclusive.
    function automatic int unsigned lives_w(input int unsigned lives);
        return (lives < 1) ? 1 : $clog2(lives + 1);
    endfunction

endpackage

// File: rtl/grace_timer.sv
// Loadable down-counter timing the post-hit invincibility window in game ticks.
module grace_timer #(
    parameter int unsigned GRACE_TICKS = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic tick,
    output logic active,
    output logic expire
);

    localparam int unsigned CW = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CW'(GRACE_TICKS);
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign active = (count_q != '0);
    assign expire = tick && (count_q == CW'(1));

endmodule

// File: rtl/collision_tracker.sv
// Collision/lives tracker: pipe and ground hits, grace window, sticky game-over.
// Optional pass counter output enabled by defining SCORE_EN.
module collision_tracker
    import collision_pkg::*;
#(
    parameter int unsigned ROWS        = 8,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned GRACE_TICKS = 4,
    localparam int unsigned LW         = lives_w(LIVES)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            tick,
    input  logic            restart,
    input  logic [ROWS-1:0] bird,
    input  logic [ROWS-1:0] pipe,
    input  logic            ground_hit,
    output logic            hit_pulse,
    output logic [LW-1:0]   lives_left,
    output logic            grace_active,
    output logic            loss_detect
`ifdef SCORE_EN
    ,
    output logic [SCORE_W-1:0] score
`endif
);

    coll_state_t   state_q, state_d;
    logic [LW-1:0] lives_q, lives_d;
    logic          hit_q, hit_d;
    logic          loss_q;
    logic          pipe_coll;
    logic          grace_load;
    logic          grace_clear;
    logic          grace_expire;
    logic          grace_run;

    assign pipe_coll = |(bird & pipe);

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        hit_d      = 1'b0;
        grace_load = 1'b0;
        if (tick) begin
            unique case (state_q)
                PLAY: begin
                    if (ground_hit) begin
                        state_d = DEAD;
                        lives_d = '0;
                        hit_d   = 1'b1;
                    end else if (pipe_coll) begin
                        hit_d = 1'b1;
                        if (lives_q <= LW'(1)) begin
                            state_d = DEAD;
                            lives_d = '0;
                        end else begin
                            lives_d = lives_q - LW'(1);
                            if (GRACE_TICKS > 0) begin
                                state_d    = GRACE;
                                grace_load = 1'b1;
                            end
                        end
                    end
                end
                GRACE: begin
                    // Pipe overlap is ignored here; only the ground can still kill.
                    if (ground_hit) begin
                        state_d = DEAD;
                        lives_d = '0;
                        hit_d   = 1'b1;
                    end else if (grace_expire) begin
                        state_d = PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grace_clear = restart || (state_d == DEAD);

    grace_timer #(
        .GRACE_TICKS(GRACE_TICKS)
    ) u_grace_timer (
        .clock (clock),
        .reset (reset),
        .clear (grace_clear),
        .load  (grace_load),
        .tick  (tick),
        .active(grace_run),
        .expire(grace_expire)
    );

    always_ff @(posedge clock) begin
        if (!reset || restart) begin
            state_q <= PLAY;
            lives_q <= LW'(LIVES);
            hit_q   <= 1'b0;
            loss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            hit_q   <= hit_d;
            loss_q  <= (state_d == DEAD);
        end
    end

    assign hit_pulse    = hit_q;
    assign lives_left   = lives_q;
    assign grace_active = grace_run;
    assign loss_detect  = loss_q;

`ifdef SCORE_EN
    logic               prev_nz_q;
    logic [SCORE_W-1:0] score_q;
    logic               pass;

    // A pipe has been passed when its column empties; no credit on the dying tick.
    assign pass = tick && (state_q != DEAD) && (state_d != DEAD) && prev_nz_q && (pipe == '0);

    always_ff @(posedge clock) begin
        if (!reset || restart) begin
            prev_nz_q <= 1'b0;
            score_q   <= '0;
        end else begin
            if (tick) begin
                prev_nz_q <= |pipe;
            end
            if (pass && (score_q != '1)) begin
                score_q <= score_q + SCORE_W'(1);
            end
        end
    end

    assign score = score_q;
`endif

endmodule
